// File: rtl/countdown_timer.sv
// Programmable down-counter with load, start/stop, optional auto-reload and a one-cycle
// expiry pulse. Control priority is load > stop > start.
module countdown_timer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  done
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRun     = 2'd1;
    localparam logic [1:0] StPaused  = 2'd2;
    localparam logic [1:0] StExpired = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] count_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d;
    logic                  done_d;
    logic                  tick;

    always_comb begin
        state_d  = state_q;
        count_d  = count;
        reload_d = reload_q;
        done_d   = 1'b0;
        tick     = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = StIdle;
        end else if (stop) begin
            if (state_q == StRun) begin
                state_d = StPaused;
            end
        end else begin
            // The start edge itself counts as the first tick; a zero count can never run.
            case (state_q)
                StIdle, StPaused: tick = start && (count != '0);
                StRun:            tick = (count != '0);
                default:          tick = 1'b0;
            endcase

            if (tick) begin
                state_d = StRun;
                if (count == DATA_WIDTH'(1)) begin
                    done_d = 1'b1;
                    if (auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = StExpired;
                    end
                end else begin
                    count_d = count - DATA_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            count    <= '0;
            reload_q <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            reload_q <= reload_d;
            running  <= (state_d == StRun);
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal expectations
// followed by randomized control traffic compared against a behavioural model every cycle.
module tb_countdown_timer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         running;
    logic         done;

    countdown_timer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .count      (count),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Model: remaining time, stored duration, and a coarse phase of the timer.
    localparam int PIdle = 0, PRun = 1, PPaused = 2, PExpired = 3;
    int           m_phase;
    int unsigned  m_left;
    int unsigned  m_period;
    bit           m_done;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  cmp_en      = 1'b0;

    task automatic model_reset();
        m_phase  = PIdle;
        m_left   = 0;
        m_period = 0;
        m_done   = 1'b0;
    endtask

    // One clock edge of the timer as described behaviourally.
    task automatic model_step();
        bit advance;
        m_done = 1'b0;
        if (load) begin
            m_left   = int'(load_value);
            m_period = int'(load_value);
            m_phase  = PIdle;
        end else if (stop) begin
            if (m_phase == PRun) m_phase = PPaused;
        end else begin
            advance = (m_left > 0) &&
                      ((m_phase == PRun) ||
                       (start && (m_phase == PIdle || m_phase == PPaused)));
            if (advance) begin
                m_left  = m_left - 1;
                m_phase = PRun;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    if (auto_reload) m_left = m_period;
                    else             m_phase = PExpired;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit l, input logic [W-1:0] v, input bit s, input bit p, input bit a);
        load        = l;
        load_value  = v;
        start       = s;
        stop        = p;
        auto_reload = a;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            vectors++;
            if (count !== W'(m_period) && 1'b0) begin
            end
            if (count !== W'(m_left) || running !== (m_phase == PRun) || done !== m_done) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t count=%0h/%0h running=%0b/%0b done=%0b/%0b",
                         $time, count, W'(m_left), running, (m_phase == PRun), done, m_done);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(0, '0, 0, 0, 0);
        model_reset();
        cyc();
        cyc();
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_running", 32'(running), 32'h0);
        chk("reset_done", 32'(done), 32'h0);

        // Basic countdown from 5.
        drive(1, 16'd5, 0, 0, 0); cyc();
        chk("basic_loaded", 32'(count), 32'd5);
        drive(0, 16'd0, 1, 0, 0); cyc();
        chk("basic_first_tick", 32'(count), 32'd4);
        chk("basic_running", 32'(running), 32'd1);
        drive(0, 16'd0, 0, 0, 0);
        cyc(); cyc(); cyc();
        chk("basic_at_1", 32'(count), 32'd1);
        chk("basic_done_early", 32'(done), 32'd0);
        cyc();
        chk("basic_zero", 32'(count), 32'd0);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_run_fall", 32'(running), 32'd0);
        drive(0, 16'd0, 1, 0, 0); cyc();
        chk("expired_hold", 32'(count), 32'd0);
        chk("expired_done_once", 32'(done), 32'd0);

        // Pause and resume from 10.
        drive(1, 16'd10, 0, 0, 0); cyc();
        drive(0, 16'd0, 1, 0, 0); cyc();
        drive(0, 16'd0, 0, 0, 0); cyc(); cyc();
        chk("pause_at_7", 32'(count), 32'd7);
        drive(0, 16'd0, 0, 1, 0); cyc();
        drive(0, 16'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc();
        chk("paused_hold", 32'(count), 32'd7);
        chk("paused_not_running", 32'(running), 32'd0);
        drive(0, 16'd0, 1, 1, 0); cyc();
        chk("start_stop_paused", 32'(count), 32'd7);
        chk("start_stop_not_running", 32'(running), 32'd0);
        drive(0, 16'd0, 1, 0, 0); cyc();
        chk("resume_6", 32'(count), 32'd6);
        drive(0, 16'd0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc();
        chk("resume_done", 32'(done), 32'd1);

        // Auto-reload with period 3.
        drive(1, 16'd3, 0, 0, 1); cyc();
        drive(0, 16'd0, 1, 0, 1); cyc();
        chk("ar_first", 32'(count), 32'd2);
        drive(0, 16'd0, 0, 0, 1); cyc();
        chk("ar_one", 32'(count), 32'd1);
        cyc();
        chk("ar_reload", 32'(count), 32'd3);
        chk("ar_done", 32'(done), 32'd1);
        chk("ar_running", 32'(running), 32'd1);
        for (int i = 0; i < 9; i++) cyc();

        // Load while running aborts to IDLE.
        drive(1, 16'd9, 1, 0, 0); cyc();
        chk("load_abort_count", 32'(count), 32'd9);
        chk("load_abort_running", 32'(running), 32'd0);

        // Period-1 auto-reload keeps done high.
        drive(1, 16'd1, 0, 0, 1); cyc();
        drive(0, 16'd0, 1, 0, 1); cyc();
        drive(0, 16'd0, 0, 0, 1); cyc();
        chk("p1_count", 32'(count), 32'd1);
        chk("p1_done", 32'(done), 32'd1);

        // Load 1 then start, no auto-reload.
        drive(1, 16'd1, 0, 0, 0); cyc();
        drive(0, 16'd0, 1, 0, 0); cyc();
        chk("one_done", 32'(done), 32'd1);
        chk("one_count", 32'(count), 32'd0);

        // Zero load cannot start.
        drive(1, 16'd0, 0, 0, 0); cyc();
        drive(0, 16'd0, 1, 0, 0); cyc();
        chk("zero_no_run", 32'(running), 32'd0);

        // Async reset mid-run.
        drive(1, 16'hFFFF, 0, 0, 0); cyc();
        drive(0, 16'd0, 1, 0, 0); cyc();
        drive(0, 16'd0, 0, 0, 0); cyc();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_running", 32'(running), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        cyc();
        reset = 1'b0;
        drive(0, 16'd0, 1, 0, 0); cyc();
        chk("post_reset_start", 32'(count), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_reset();
                cyc();
                reset = 1'b0;
            end else begin
                cyc();
            end
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Programmable down-counter that reloads, runs, pauses and flags expiry.
- Complements the up-counting stopwatch: software loads a duration, starts it, and receives a one-cycle `done` pulse when it reaches zero.
- Optional auto-reload turns it into a periodic tick generator for the same timer subsystem.

Parameters:
- DATA_WIDTH, 16, width of the count, load value and reload register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture load_value into the count and reload registers, then stop.
- load_value  input  DATA_WIDTH  duration in cycles (unsigned).
- start  input  1  begin or resume counting.
- stop  input  1  pause counting; count is held.
- auto_reload  input  1  on expiry, reload from the reload register and keep running.
- count  output  DATA_WIDTH  current remaining count (registered).
- running  output  1  high while in RUN (registered).
- done  output  1  one-cycle registered pulse on expiry.

Behaviour:
- Reset is asynchronous: reset high forces, with no clock, state=IDLE, count=0, reload_reg=0, running=0, done=0.
- State machine states: IDLE, RUN, PAUSED, EXPIRED. running=1 only in RUN.
- Control priority per cycle is load > stop > start.
- done defaults to 0 every cycle; it is set only by the expiry rule below.
- load, any state:
  - count<=load_value and reload_reg<=load_value.
  - state<=IDLE, done<=0.
  - Aborts an active run.
- stop:
  - In RUN: state<=PAUSED; count unchanged that cycle.
  - In other states: no effect.
  - Simultaneous start+stop: stop wins.
- start in IDLE or PAUSED:
  - If count!=0: state<=RUN, and count decrements in the same cycle (start edge counts as the first tick).
  - If count==0: ignored, state unchanged.
- start in RUN or EXPIRED: ignored.
- RUN, count>1: count<=count-1.
- RUN, count==1 (expiry): done<=1. auto_reload is sampled in this cycle.
  - auto_reload=1: count<=reload_reg, stay in RUN. Period is exactly reload_reg cycles between done pulses.
  - auto_reload=0: count<=0, state<=EXPIRED.
- Expiry on the start cycle: start applied with count==1 expires immediately, following the expiry rule above.
- reload_reg==1 with auto_reload=1: done stays high every cycle and count stays 1.
- EXPIRED: count holds 0, running=0. Only load leaves this state.
- Arithmetic:
  - Unsigned, DATA_WIDTH bits.
  - The counter never decrements from 0, so there is no underflow wrap.
  - load_value=0 yields a timer that cannot start.
- Latency:
  - count, running and done are visible the cycle after the controlling input edge.
  - done asserts in the same cycle count shows 0, or shows reload_reg in auto-reload mode.
- Reset asserted mid-run clears everything immediately. After deassertion the block sits in IDLE with count=0.

Test Plan:
- Basic countdown: load=1 with load_value=5, then start pulse, auto_reload=0 -> count 4,3,2,1,0 on successive cycles; done=1 exactly on the cycle count=0; running falls to 0 with it; count then holds 0.
- Pause/resume: load 10, start, stop after count=7, idle 4 cycles, start -> count held at 7 while paused; running=0 while paused; resumes 6,5,...; done once at 0.
- Auto-reload: load 3, auto_reload=1, start, run 12 cycles -> count 2,1,3,2,1,3...; done pulses every 3 cycles; running stays 1.
- Priority and edge cases:
  - start+stop in the same cycle from PAUSED -> stays PAUSED.
  - load+start in RUN -> count=load_value, state IDLE.
  - start with count=0 -> no change.
  - load 1 then start -> done on the next cycle, count=0.
- Async reset mid-run: load 0xFFFF, start, assert reset between clock edges -> count=0, running=0, done=0 before the next edge; start afterwards is ignored until a load.
